pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the multi-cycle datapath. It holds the current instruction address and advances it by a fixed step once every CPI clock cycles. Over the fixed add-4-every-4-cycles incrementer it adds:
- exact, configurable cycle period
- synchronous reset to a reset vector
- stall
- branch/jump load with defined priority
- a phase counter and an advance strobe for the control unit

---
 rtl/pc_sequencer.sv | 78 +++++++
 tb/tb_pc_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter advancing by STEP every CPI cycles, with stall, load and phase strobe.
// Define PC_ALIGN_CHECK_EN to force loaded addresses STEP-aligned and flag misaligned loads.
module pc_sequencer #(
  parameter int ADDR_W = 32,
  parameter int STEP = 4,
  parameter int CPI = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int CNT_W = (CPI > 1) ? $clog2(CPI) : 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Stall,
  input  logic              Load_En,
  input  logic [ADDR_W-1:0] Load_Addr,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] Next_PC,
  output logic [CNT_W-1:0]  Phase,
  output logic              Advance,
  output logic              Loaded
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic              Misalign
`endif
);
  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CPI - 1);
  logic [ADDR_W-1:0] pc_q, pc_d, load_pc;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic advance_q, advance_d, loaded_q, loaded_d;
`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign load_pc = Load_Addr & ~(STEP_V - 1'b1);
  assign misalign_d = Load_En && |(Load_Addr & (STEP_V - 1'b1));
  assign Misalign = misalign_q;
`else
  assign load_pc = Load_Addr;
`endif
  assign Next_PC = pc_q + STEP_V;
  assign PC = pc_q;
  assign Phase = phase_q;
  assign Advance = advance_q;
  assign Loaded = loaded_q;
  // Load beats stall and beats an advance landing on the same edge.
  always_comb begin
    pc_d = pc_q;
    phase_d = phase_q;
    advance_d = 1'b0;
    loaded_d = 1'b0;
    if (Load_En) begin
      pc_d = load_pc;
      phase_d = '0;
      loaded_d = 1'b1;
    end else if (!Stall) begin
      advance_d = phase_q == LAST;
      pc_d = advance_d ? Next_PC : pc_q;
      phase_d = advance_d ? '0 : phase_q + 1'b1;
    end
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q <= RESET_PC;
      phase_q <= '0;
      advance_q <= 1'b0;
      loaded_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      pc_q <= pc_d;
      phase_q <= phase_d;
      advance_q <= advance_d;
      loaded_q <= loaded_d;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: vector table, hand sequences and a randomized model check for pc_sequencer.
module tb_pc_sequencer;
  localparam int CPI = 4;
  localparam int STEP = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, stall, ld;
  logic [31:0] addr, pc, npc;
  logic [1:0] phase;
  logic adv, loaded;
  logic b_rst, b_stall, b_ld;
  logic [31:0] b_addr, b_pc, b_npc;
  logic [0:0] b_phase;
  logic b_adv, b_loaded;
`ifdef PC_ALIGN_CHECK_EN
  logic mis, b_mis;
`endif
  pc_sequencer #(.ADDR_W(32), .STEP(STEP), .CPI(CPI), .RESET_PC(32'h0)) dut_a (
    .Clk(clk), .Rst(rst), .Stall(stall), .Load_En(ld), .Load_Addr(addr),
    .PC(pc), .Next_PC(npc), .Phase(phase), .Advance(adv), .Loaded(loaded)
`ifdef PC_ALIGN_CHECK_EN
    , .Misalign(mis)
`endif
  );
  pc_sequencer #(.ADDR_W(32), .STEP(8), .CPI(1), .RESET_PC(32'h40)) dut_b (
    .Clk(clk), .Rst(b_rst), .Stall(b_stall), .Load_En(b_ld), .Load_Addr(b_addr),
    .PC(b_pc), .Next_PC(b_npc), .Phase(b_phase), .Advance(b_adv), .Loaded(b_loaded)
`ifdef PC_ALIGN_CHECK_EN
    , .Misalign(b_mis)
`endif
  );
  int checks = 0, errors = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  task automatic apply(input logic r, input logic s, input logic l, input logic [31:0] a);
    @(negedge clk);
    rst = r; stall = s; ld = l; addr = a;
    @(posedge clk);
    #1;
  endtask
  task automatic b_apply(input logic r);
    @(negedge clk);
    b_rst = r;
    @(posedge clk);
    #1;
  endtask
  typedef struct {
    string n;
    logic r, s, l;
    logic [31:0] a, pc;
    int ph;
    logic adv, ldd;
  } vec_t;
  vec_t v[$];
  function automatic void add(input string n, input logic r, input logic s, input logic l,
                              input logic [31:0] a, input logic [31:0] p, input int ph,
                              input logic ad, input logic lo);
    vec_t t;
    t.n = n; t.r = r; t.s = s; t.l = l; t.a = a; t.pc = p; t.ph = ph; t.adv = ad; t.ldd = lo;
    v.push_back(t);
  endfunction
  logic [31:0] m_pc;
  int m_cnt;
  logic m_adv, m_ld, m_mis;
  initial begin
    rst = 1; stall = 0; ld = 0; addr = 0;
    b_rst = 1; b_stall = 0; b_ld = 0; b_addr = 0;
    add("reset1", 1, 0, 0, 0, 32'h0, 0, 0, 0);
    add("reset2", 1, 0, 0, 0, 32'h0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) add("run0", 0, 0, 0, 0, 32'h0, i, 0, 0);
    add("adv4", 0, 0, 0, 0, 32'h4, 0, 1, 0);
    for (int i = 1; i <= 3; i++) add("run4", 0, 0, 0, 0, 32'h4, i, 0, 0);
    add("adv8", 0, 0, 0, 0, 32'h8, 0, 1, 0);
    add("run8", 0, 0, 0, 0, 32'h8, 1, 0, 0);
    add("run8", 0, 0, 0, 0, 32'h8, 2, 0, 0);
    for (int i = 0; i < 5; i++) add("stall", 0, 1, 0, 0, 32'h8, 2, 0, 0);
    add("unstall", 0, 0, 0, 0, 32'h8, 3, 0, 0);
    add("advC", 0, 0, 0, 0, 32'hC, 0, 1, 0);
    for (int i = 1; i <= 3; i++) add("runC", 0, 0, 0, 0, 32'hC, i, 0, 0);
    add("load_vs_adv", 0, 1, 1, 32'h100, 32'h100, 0, 0, 1);
    for (int i = 1; i <= 3; i++) add("run100", 0, 0, 0, 0, 32'h100, i, 0, 0);
    add("adv104", 0, 0, 0, 0, 32'h104, 0, 1, 0);
    add("midrst_pre", 0, 0, 0, 0, 32'h104, 1, 0, 0);
    add("midrst", 1, 0, 0, 0, 32'h0, 0, 0, 0);
    add("load_wrap", 0, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 0, 1);
    for (int i = 1; i <= 3; i++) add("runwrap", 0, 0, 0, 0, 32'hFFFFFFFC, i, 0, 0);
    add("wrap", 0, 0, 0, 0, 32'h0, 0, 1, 0);
    foreach (v[i]) begin
      apply(v[i].r, v[i].s, v[i].l, v[i].a);
      chk({v[i].n, ".pc"}, pc, v[i].pc);
      chk({v[i].n, ".phase"}, 32'(phase), 32'(v[i].ph));
      chk({v[i].n, ".adv"}, 32'(adv), 32'(v[i].adv));
      chk({v[i].n, ".loaded"}, 32'(loaded), 32'(v[i].ldd));
      chk({v[i].n, ".next_pc"}, npc, v[i].pc + 32'(STEP));
    end
    apply(0, 0, 1, 32'h103);
`ifdef PC_ALIGN_CHECK_EN
    chk("align.pc", pc, 32'h100);
    chk("align.mis", 32'(mis), 1);
    apply(0, 0, 1, 32'h200);
    chk("align2.pc", pc, 32'h200);
    chk("align2.mis", 32'(mis), 0);
    apply(0, 0, 0, 0);
    chk("align3.mis", 32'(mis), 0);
`else
    chk("noalign.pc", pc, 32'h103);
    apply(0, 0, 0, 0);
    chk("noalign.run", pc, 32'h103);
`endif
    b_apply(1);
    b_apply(1);
    chk("b.reset.pc", b_pc, 32'h40);
    chk("b.reset.adv", 32'(b_adv), 0);
    for (int i = 1; i <= 3; i++) begin
      b_apply(0);
      chk("b.run.pc", b_pc, 32'h40 + 32'(8 * i));
      chk("b.run.adv", 32'(b_adv), 1);
      chk("b.run.phase", 32'(b_phase), 0);
    end
    b_apply(1);
    chk("b.midrst.pc", b_pc, 32'h40);
    b_apply(0);
    chk("b.after.pc", b_pc, 32'h48);
    apply(1, 0, 0, 0);
    m_pc = 0; m_cnt = 0; m_adv = 0; m_ld = 0; m_mis = 0;
    for (int k = 0; k < 400; k++) begin
      logic r, s, l;
      logic [31:0] a;
      r = $urandom_range(0, 49) == 0;
      l = $urandom_range(0, 9) == 0;
      s = $urandom_range(0, 4) == 0;
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFF0 | (a & 32'hF);
      apply(r, s, l, a);
      m_mis = 0;
      if (r) begin
        m_pc = 0; m_cnt = 0; m_adv = 0; m_ld = 0;
      end else if (l) begin
`ifdef PC_ALIGN_CHECK_EN
        m_pc = a - (a % STEP);
        m_mis = (a % STEP) != 0;
`else
        m_pc = a;
`endif
        m_cnt = 0; m_adv = 0; m_ld = 1;
      end else if (s) begin
        m_adv = 0; m_ld = 0;
      end else begin
        m_cnt++;
        m_ld = 0;
        m_adv = (m_cnt % CPI) == 0;
        if (m_adv) m_pc = m_pc + STEP;
      end
      chk("rnd.pc", pc, m_pc);
      chk("rnd.phase", 32'(phase), 32'(m_cnt % CPI));
      chk("rnd.adv", 32'(adv), 32'(m_adv));
      chk("rnd.loaded", 32'(loaded), 32'(m_ld));
      chk("rnd.next_pc", npc, m_pc + STEP);
`ifdef PC_ALIGN_CHECK_EN
      chk("rnd.mis", 32'(mis), 32'(m_mis));
`endif
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
